// File: rtl/out_signature_acc.sv
// Folds a window of three-word output steps into a 32-bit FNV-1a style signature.
// Each accepted step is hashed one word per cycle, so a new step can be taken every fourth cycle.
module out_signature_acc #(
  parameter int unsigned NUM_STEPS = 16,
  parameter logic [31:0] SEED      = 32'h811C9DC5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] out_0,
  input  logic [31:0] out_1,
  input  logic [31:0] out_2,
  output logic [31:0] sig,
  output logic        sig_valid,
  input  logic        sig_ready,
  output logic [15:0] step_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FOLD0,
    FOLD1,
    FOLD2,
    EMIT
  } state_t;

  localparam logic [31:0] FNV_PRIME = 32'h01000193;
  localparam logic [15:0] LAST_STEP = 16'(NUM_STEPS);

  state_t      state;
  state_t      state_next;
  logic [31:0] h;
  logic [95:0] hold;
  logic [31:0] word;
  logic [31:0] h_fold;

  // Pick the word of the captured step that this fold cycle consumes.
  always_comb begin
    word = hold[31:0];
    case (state)
      FOLD1:   word = hold[63:32];
      FOLD2:   word = hold[95:64];
      default: word = hold[31:0];
    endcase
  end

  assign h_fold = (h ^ word) * FNV_PRIME;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (in_valid) state_next = FOLD0;
      FOLD0:   state_next = FOLD1;
      FOLD1:   state_next = FOLD2;
      FOLD2:   state_next = (step_count == LAST_STEP) ? EMIT : ACCUM;
      EMIT:    if (sig_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only, so in_valid never reaches in_ready.
  assign in_ready  = (state == ACCUM);
  assign sig_valid = (state == EMIT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      h          <= SEED;
      sig        <= '0;
      step_count <= '0;
      hold       <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            h          <= SEED;
            step_count <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            hold <= {out_2, out_1, out_0};
            if (step_count != LAST_STEP) step_count <= step_count + 16'd1;
          end
        end
        FOLD0, FOLD1: h <= h_fold;
        FOLD2: begin
          h <= h_fold;
          // sig is only refreshed by a completed window, so IDLE keeps the last result.
          if (step_count == LAST_STEP) sig <= h_fold;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/out_signature_acc.md
OUT_SIGNATURE_ACC -- requirements
Module: out_signature_acc

Interface
REQ-001 The block SHALL have parameter NUM_STEPS, default 16, meaning the number of output steps folded into one signature (legal range 1..65535).
REQ-002 The block SHALL have parameter SEED, default 32'h811C9DC5, meaning the initial hash value loaded at window start.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to open a signature window.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a design-under-test output step is present on out_0..out_2.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a step this cycle.
REQ-008 The block SHALL have ports out_0, out_1 and out_2, inputs, 32 bits each: the three output words of one step, with out_0 least significant.
REQ-009 The block SHALL have port sig, output, 32 bits: the completed signature.
REQ-010 The block SHALL have port sig_valid, output, 1 bit: sig is valid and held.
REQ-011 The block SHALL have port sig_ready, input, 1 bit: the consumer takes sig.
REQ-012 The block SHALL have port step_count, output, 16 bits: the number of steps accepted in the current window.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 The block SHALL implement FSM states IDLE, ACCUM, FOLD0, FOLD1, FOLD2 and EMIT.
REQ-015 IDLE SHALL go to ACCUM when start=1, loading h=SEED and step_count=0 on the same edge; start SHALL be ignored in all other states.
REQ-016 in_ready SHALL equal 1 only in ACCUM, as a registered state decode with no combinational path from in_valid.
REQ-017 In ACCUM, in_valid&&in_ready SHALL capture out_0..out_2 into a 96-bit holding register, increment step_count and go to FOLD0.
REQ-018 FOLDk (k=0,1,2) SHALL perform h <= (h ^ word_k) * 32'h01000193, truncated mod 2^32; word_0 SHALL be out_0, word_1 out_1, word_2 out_2.
REQ-019 FOLD2 SHALL go to EMIT if step_count==NUM_STEPS, else to ACCUM; the minimum step-to-step spacing SHALL therefore be 4 cycles.
REQ-020 In EMIT, sig SHALL equal h and sig_valid SHALL equal 1; sig and sig_valid SHALL hold stable until sig_ready=1, whereupon the block SHALL go to IDLE with sig_valid=0 on the next cycle.
REQ-021 sig SHALL retain the last emitted value in IDLE; only sig_valid qualifies it.
REQ-022 A start asserted in the same cycle as the EMIT handshake SHALL be ignored; a new window SHALL require start in IDLE.
REQ-023 in_valid outside ACCUM SHALL have no effect; data SHALL NOT be consumed or counted.
REQ-024 step_count SHALL never exceed NUM_STEPS and SHALL NOT wrap.
REQ-025 sig_ready outside EMIT SHALL have no effect.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL enter IDLE with h=SEED, sig=0, sig_valid=0, in_ready=0, step_count=0, busy=0 and the holding register cleared.
REQ-027 Reset SHALL override every other input, including mid-fold and mid-EMIT; no partial signature SHALL be emitted afterward.

Verification
REQ-028 Single step: SEED=0, NUM_STEPS=1, start, then step (1,0,0) -> h after FOLD0/FOLD1/FOLD2 = 0x01000193/0x26027A69/0x3EE6B34B; sig=0x3EE6B34B, sig_valid=1 the cycle after FOLD2.
REQ-029 Zero data: SEED=0, NUM_STEPS=4, four steps (0,0,0) -> sig=0, step_count=4.
REQ-030 Backpressure: hold sig_ready=0 for 10 cycles in EMIT -> sig/sig_valid stable, in_ready=0, start ignored; sig_ready=1 -> IDLE, busy=0 next cycle.
REQ-031 Continuous in_valid=1 with default parameters -> exactly 16 accepts spaced 4 cycles apart; in_ready=0 during FOLD and EMIT; result matches an FNV-1a word-wise reference model.
REQ-032 Reset mid-window: rst in FOLD1 of step 3 -> all outputs at reset values next cycle; a fresh window then yields the same sig as an uninterrupted run.
REQ-033 Stray inputs: in_valid and sig_ready pulsed in IDLE -> step_count=0, no state change, sig_valid=0.
